// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard unit and its forwarding selectors.
package hazard_pkg;

  localparam int REG_AW_DEFAULT = 5;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mdu_state_e;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding select for one E-stage source operand. M has priority over W,
// and x0 is never forwarded.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEFAULT
) (
  input  logic [REG_AW-1:0] RsE,
  input  logic [REG_AW-1:0] RdM,
  input  logic              RegWriteM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteW,
  output logic [1:0]        Fwd
);

  // pick the youngest in-flight producer of RsE
  always_comb begin
    Fwd = FWD_RF;
    if (RegWriteM && (RsE == RdM) && (RsE != '0)) begin
      Fwd = FWD_M;
    end else if (RegWriteW && (RsE == RdW) && (RsE != '0)) begin
      Fwd = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_mdu.sv
// Hazard unit for the 5-stage RV32 pipeline: M/W forwarding, load-use stall,
// branch/jump flush and an occupancy FSM holding multi-cycle MDU ops in E.
// Optional build macro HAZARD_PERF_EN adds stall/flush performance counters.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no MDU op in flight; a new MduStartE is accepted here
// BUSY  | MDU op held in E, cnt counts down the remaining held cycles
// DONE  | last E cycle of the op; E advances, MduStartE is ignored
module hazard_mdu
  import hazard_pkg::*;
#(
  parameter  int REG_AW  = REG_AW_DEFAULT,
  parameter  int MDU_LAT = 4,
  localparam int CNT_W   = $clog2(MDU_LAT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic              RegWriteE,
  input  logic              ResultSrcE_zero,
  input  logic              MduStartE,
  input  logic              PCSrcE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              MduBusy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  // An op with MDU_LAT>=2 stalls in the start cycle; BUSY covers the rest
  // of the held cycles, so the down-counter starts at MDU_LAT-3.
  localparam logic             MDU_MULTI = (MDU_LAT >= 2);
  localparam logic             MDU_LONG  = (MDU_LAT >= 3);
  localparam logic [CNT_W-1:0] CNT_LOAD  = MDU_LONG ? CNT_W'(MDU_LAT - 3) : '0;

  mdu_state_e       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             lw_stall;
  logic             mdu_stall;

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .RsE       (Rs1E),
    .RdM       (RdM),
    .RegWriteM (RegWriteM),
    .RdW       (RdW),
    .RegWriteW (RegWriteW),
    .Fwd       (ForwardAE)
  );

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .RsE       (Rs2E),
    .RdM       (RdM),
    .RegWriteM (RegWriteM),
    .RdW       (RdW),
    .RegWriteW (RegWriteW),
    .Fwd       (ForwardBE)
  );

  // load in E whose destination is read by the instruction in D
  always_comb begin
    lw_stall = ResultSrcE_zero && RegWriteE && (RdE != '0) &&
               ((Rs1D == RdE) || (Rs2D == RdE));
  end

  // occupancy state register and down-counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // next-state, terminal-count compare and MDU stall request
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    mdu_stall = 1'b0;
    case (state)
      IDLE: begin
        if (MduStartE && MDU_MULTI) begin
          mdu_stall = 1'b1;
          if (MDU_LONG) begin
            state_n = BUSY;
            cnt_n   = CNT_LOAD;
          end else begin
            state_n = DONE;
          end
        end
      end
      BUSY: begin
        mdu_stall = 1'b1;
        if (cnt == '0) begin
          state_n = DONE;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // stage controls; a held E must keep D/E contents, so MDU wins over flushes
  always_comb begin
    StallF  = lw_stall | mdu_stall;
    StallD  = lw_stall | mdu_stall;
    StallE  = mdu_stall;
    FlushM  = mdu_stall;
    FlushD  = PCSrcE & ~mdu_stall;
    FlushE  = (lw_stall | PCSrcE) & ~mdu_stall;
    MduBusy = (state != IDLE);
  end

`ifdef HAZARD_PERF_EN
  // free-running event counters, wrapping modulo 2^32
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      perf_stall_cnt <= perf_stall_cnt + {31'd0, StallF};
      perf_flush_cnt <= perf_flush_cnt + {31'd0, FlushE};
    end
  end
`endif

endmodule

// File: tb/tb_hazard_mdu.sv
// Scoreboard bench for hazard_mdu: three instances (MDU_LAT 4, 2, 1) share
// the same stimulus; a rule-level model predicts each cycle's outputs.
module tb_hazard_mdu;

  typedef struct packed {
    logic       reset;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       rwe, rsz, start, pc, rwm, rww;
  } stim_t;

  typedef struct packed {
    logic        sf, sd, se, fd, fe, fm, bz;
    logic [1:0]  fa, fb;
    logic [31:0] ps, pf;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic RegWriteE, ResultSrcE_zero, MduStartE, PCSrcE, RegWriteM, RegWriteW;

  logic       sf_o[3], sd_o[3], se_o[3], fd_o[3], fe_o[3], fm_o[3], bz_o[3];
  logic [1:0] fa_o[3], fb_o[3];
  logic [31:0] ps_o[3], pf_o[3];

  exp_t q[3][$];
  int stall_left[3], busy_left[3];
  logic [31:0] m_ps[3], m_pf[3];
  int npass = 0, ntotal = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    hazard_mdu #(.REG_AW(5), .MDU_LAT((g == 0) ? 4 : (g == 1) ? 2 : 1)) dut (
      .clk(clk), .reset(reset),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
      .RegWriteE(RegWriteE), .ResultSrcE_zero(ResultSrcE_zero),
      .MduStartE(MduStartE), .PCSrcE(PCSrcE),
      .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .StallF(sf_o[g]), .StallD(sd_o[g]), .StallE(se_o[g]),
      .FlushD(fd_o[g]), .FlushE(fe_o[g]), .FlushM(fm_o[g]),
      .ForwardAE(fa_o[g]), .ForwardBE(fb_o[g]), .MduBusy(bz_o[g])
`ifdef HAZARD_PERF_EN
      , .perf_stall_cnt(ps_o[g]), .perf_flush_cnt(pf_o[g])
`endif
    );
`ifndef HAZARD_PERF_EN
    assign ps_o[g] = '0;
    assign pf_o[g] = '0;
`endif
  end

  function automatic int lat_of(input int i);
    return (i == 0) ? 4 : (i == 1) ? 2 : 1;
  endfunction

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs, rdm, input logic wm,
                                         input logic [4:0] rdw, input logic ww);
    if (rs != 0 && wm && rs == rdm) return 2'b10;
    if (rs != 0 && ww && rs == rdw) return 2'b01;
    return 2'b00;
  endfunction

  function automatic stim_t idle_s();
    stim_t s;
    s = '0;
    return s;
  endfunction

  task automatic check(input string nm, input int lat, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s lat=%0d actual=%0h required=%0h", nm, lat, act, exp);
  endtask

  // apply one cycle of stimulus and push the predicted response per instance
  task automatic cycle(input stim_t s);
    logic lw, ms, start_now;
    int lat;
    exp_t e;
    @(negedge clk);
    reset = s.reset; Rs1D = s.rs1d; Rs2D = s.rs2d; Rs1E = s.rs1e; Rs2E = s.rs2e;
    RdE = s.rde; RdM = s.rdm; RdW = s.rdw; RegWriteE = s.rwe;
    ResultSrcE_zero = s.rsz; MduStartE = s.start; PCSrcE = s.pc;
    RegWriteM = s.rwm; RegWriteW = s.rww;
    lw = s.rsz && s.rwe && s.rde != 0 && (s.rs1d == s.rde || s.rs2d == s.rde);
    for (int i = 0; i < 3; i++) begin
      lat = lat_of(i);
      start_now = (busy_left[i] == 0) && s.start && (lat >= 2);
      ms = start_now || (stall_left[i] > 0);
      e.sf = lw | ms; e.sd = lw | ms; e.se = ms; e.fm = ms;
      e.fd = s.pc & ~ms; e.fe = (lw | s.pc) & ~ms;
      e.bz = busy_left[i] > 0;
      e.fa = fwd_ref(s.rs1e, s.rdm, s.rwm, s.rdw, s.rww);
      e.fb = fwd_ref(s.rs2e, s.rdm, s.rwm, s.rdw, s.rww);
      e.ps = m_ps[i]; e.pf = m_pf[i];
      q[i].push_back(e);
      if (s.reset) begin
        stall_left[i] = 0; busy_left[i] = 0; m_ps[i] = 0; m_pf[i] = 0;
      end else begin
        m_ps[i] = m_ps[i] + {31'd0, e.sf};
        m_pf[i] = m_pf[i] + {31'd0, e.fe};
        if (start_now) begin
          stall_left[i] = lat - 2;
          busy_left[i]  = lat - 1;
        end else begin
          if (stall_left[i] > 0) stall_left[i]--;
          if (busy_left[i] > 0) busy_left[i]--;
        end
      end
    end
  endtask

  // monitor: compare every pending prediction against the live outputs
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      for (int i = 0; i < 3; i++) begin
        if (q[i].size() > 0) begin
          e = q[i].pop_front();
          check("StallF", lat_of(i), {31'd0, sf_o[i]}, {31'd0, e.sf});
          check("StallD", lat_of(i), {31'd0, sd_o[i]}, {31'd0, e.sd});
          check("StallE", lat_of(i), {31'd0, se_o[i]}, {31'd0, e.se});
          check("FlushD", lat_of(i), {31'd0, fd_o[i]}, {31'd0, e.fd});
          check("FlushE", lat_of(i), {31'd0, fe_o[i]}, {31'd0, e.fe});
          check("FlushM", lat_of(i), {31'd0, fm_o[i]}, {31'd0, e.fm});
          check("MduBusy", lat_of(i), {31'd0, bz_o[i]}, {31'd0, e.bz});
          check("ForwardAE", lat_of(i), {30'd0, fa_o[i]}, {30'd0, e.fa});
          check("ForwardBE", lat_of(i), {30'd0, fb_o[i]}, {30'd0, e.fb});
`ifdef HAZARD_PERF_EN
          check("perf_stall_cnt", lat_of(i), ps_o[i], e.ps);
          check("perf_flush_cnt", lat_of(i), pf_o[i], e.pf);
`endif
        end
      end
    end
  end

  initial begin
    stim_t s;
    for (int i = 0; i < 3; i++) begin
      stall_left[i] = 0; busy_left[i] = 0; m_ps[i] = 0; m_pf[i] = 0;
    end
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegWriteE, ResultSrcE_zero, MduStartE, PCSrcE, RegWriteM, RegWriteW} = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);

    s = idle_s(); s.reset = 1'b1; cycle(s);
    s = idle_s(); cycle(s);
    // forwarding: M wins over W, x0 never forwarded
    s = idle_s(); s.rs1e = 5; s.rdm = 5; s.rwm = 1; s.rdw = 5; s.rww = 1; cycle(s);
    s = idle_s(); s.rs1e = 6; s.rdw = 6; s.rww = 1; s.rs2e = 0; s.rdm = 0; s.rwm = 1; cycle(s);
    // load-use, then same with RdE = x0
    s = idle_s(); s.rsz = 1; s.rwe = 1; s.rde = 7; s.rs2d = 7; cycle(s);
    s.rde = 0; s.rs2d = 0; cycle(s);
    // taken branch
    s = idle_s(); s.pc = 1; cycle(s);
    // MDU op held in E
    s = idle_s(); s.start = 1; repeat (4) cycle(s);
    s = idle_s(); repeat (2) cycle(s);
    // MDU with concurrent load-use and branch
    s = idle_s(); s.start = 1; s.rsz = 1; s.rwe = 1; s.rde = 3; s.rs1d = 3; s.pc = 1;
    repeat (3) cycle(s);
    s = idle_s(); repeat (3) cycle(s);
    // reset while BUSY with cnt at terminal count
    s = idle_s(); s.start = 1; cycle(s); cycle(s);
    s.reset = 1; cycle(s);
    s = idle_s(); repeat (2) cycle(s);

    for (int n = 0; n < 2000; n++) begin
      s.reset = ($urandom_range(0, 63) == 0);
      s.rs1d = 5'($urandom_range(0, 7)); s.rs2d = 5'($urandom_range(0, 7));
      s.rs1e = 5'($urandom_range(0, 7)); s.rs2e = 5'($urandom_range(0, 7));
      s.rde  = 5'($urandom_range(0, 7)); s.rdm  = 5'($urandom_range(0, 7));
      s.rdw  = 5'($urandom_range(0, 7));
      s.rwe = 1'($urandom); s.rsz = 1'($urandom); s.rwm = 1'($urandom);
      s.rww = 1'($urandom); s.pc = ($urandom_range(0, 3) == 0);
      s.start = ($urandom_range(0, 2) == 0);
      cycle(s);
    end

    @(negedge clk);
    #5;
    for (int i = 0; i < 3; i++) check("queue_drained", lat_of(i), q[i].size(), 0);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/hazard_mdu.md
Name: hazard_mdu

Overview:
- Next-generation hazard unit for the 5-stage RV32 pipeline (F/D/E/M/W).
- Keeps combinational M/W forwarding, load-use stall and branch/jump flush.
- Adds a sequential occupancy FSM so a multi-cycle multiply/divide unit (MDU) can hold an op in E for MDU_LAT cycles.
- Optionally adds stall/flush performance counters.

Parameters:
- REG_AW, 5, register address width.
- MDU_LAT, 4, total cycles an MDU op occupies E (>=1; 1 = single-cycle MDU, FSM inert).
- CNT_W, $clog2(MDU_LAT+1), occupancy counter width (derived).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- Rs1D, Rs2D  in  REG_AW  source regs in D
- Rs1E, Rs2E, RdE  in  REG_AW  source/dest regs in E
- RegWriteE  in  1  E instr writes Rd
- ResultSrcE_zero  in  1  E instr is a load
- MduStartE  in  1  E instr is an MDU op
- PCSrcE  in  1  taken branch/jump in E
- RdM, RdW  in  REG_AW  dest regs in M, W
- RegWriteM, RegWriteW  in  1  write enables in M, W
- StallF, StallD, StallE  out  1  hold stage registers
- FlushD, FlushE, FlushM  out  1  bubble into D/E/M registers
- ForwardAE, ForwardBE  out  2  00 regfile, 01 W, 10 M
- MduBusy  out  1  FSM not IDLE

Behaviour:
- Forwarding (combinational), per source: 10 if RsXE==RdM & RegWriteM & RsXE!=0; else 01 if RsXE==RdW & RegWriteW & RsXE!=0; else 00. M wins over W.
- lwStall = ResultSrcE_zero & RegWriteE & RdE!=0 & (Rs1D==RdE | Rs2D==RdE). Rd=x0 never stalls.
- FSM states (package enum): IDLE, BUSY, DONE; counter cnt of width CNT_W.
- IDLE:
  - MduStartE & MDU_LAT>=3 -> BUSY, cnt<=MDU_LAT-3.
  - MduStartE & MDU_LAT==2 -> DONE.
  - MDU_LAT==1 -> stay IDLE.
- BUSY: cnt==0 -> DONE, else cnt<=cnt-1.
- DONE: -> IDLE unconditionally. MduStartE is ignored in DONE because the same instr is still in E.
- mduStall = (IDLE & MduStartE & MDU_LAT>=2) | BUSY.
  - Stall cycles = MDU_LAT-1; E residency = MDU_LAT cycles.
  - A back-to-back MDU op enters E the cycle after DONE and is seen in IDLE.
- Outputs:
  - StallF = StallD = lwStall | mduStall.
  - StallE = mduStall.
  - FlushM = mduStall (bubble downstream while E is held).
  - FlushD = PCSrcE & ~mduStall.
  - FlushE = (lwStall | PCSrcE) & ~mduStall.
  - MduBusy = state!=IDLE.
- Simultaneous events: mduStall has priority over lwStall/PCSrcE flushes (E is held, so the D/E contents must survive).
- Reset: state<=IDLE, cnt<=0. In the reset-following cycle with idle inputs, all outputs = 0. Reset mid-BUSY aborts the op; the next cycle is IDLE.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined, two extra outputs:
  - perf_stall_cnt (32): +1 each cycle StallF=1.
  - perf_flush_cnt (32): +1 each cycle FlushE=1.
  - Both cleared by reset, wrap modulo 2^32.
- When undefined: ports and counters are absent; everything else is identical.

Decomposition:
- Package hazard_pkg holds:
  - fwd_sel_e (FWD_RF=00, FWD_W=01, FWD_M=10).
  - mdu_state_e (IDLE/BUSY/DONE).
  - REG_AW_DEFAULT constant.
- One natural sub-module: hazard_fwd_sel, instantiated twice (A/B). Inputs RsE, RdM, RegWriteM, RdW, RegWriteW; output the 2-bit select.

Test Plan:
- Forwarding: Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardAE=10. Rs2E=0 with RdM=0, RegWriteM=1 -> ForwardBE=00.
- Load-use: ResultSrcE_zero=1, RegWriteE=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1, FlushD=0. Same with RdE=0 -> all 0.
- Branch: PCSrcE=1, no load -> FlushD=FlushE=1, StallF=0.
- MDU, MDU_LAT=4: MduStartE held high from cycle t until E advances.
  - StallF/StallD/StallE/FlushM=1 in t..t+2, 0 at t+3.
  - MduBusy=1 at t+1..t+3; IDLE at t+4.
  - Repeat with MDU_LAT=2 (one stall cycle) and MDU_LAT=1 (none).
- MDU with concurrent lwStall condition (Rs1D==RdE, ResultSrcE_zero=1 forced) and PCSrcE=1 during BUSY -> FlushD=FlushE=0, StallE=1.
- Reset asserted at BUSY cnt=0 -> next cycle MduBusy=0, all stalls 0. With HAZARD_PERF_EN, 3 stall cycles then reset -> perf_stall_cnt goes 3 -> 0.
